riscv_wb_port_arbiter: RTL and testbench
========================================

// Module: riscv_wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order W stage and a
//  long-latency unit (LU, e.g. multi-cycle mul/div) that completes out of band.
//  W-stage writes always win. LU results are buffered in a small FIFO and drained
//  on idle write-port cycles. Sits between W-stage result mux, LU and regfile.
//  Raises a stall request to the hazard unit when the buffer cannot drain.
// PARAMETERS
//  XLEN          32  datapath width
//  DEPTH         4   LU result FIFO entries; power of 2, >=2
//  STARVE_LIMIT  8   cycles head may wait before forcing a stall; >=1
// PORTS
//  i_clk             in   1        clock
//  i_rstn            in   1        synchronous reset, active-low
//  i_pipe_wr_en      in   1        W-stage register write enable
//  i_pipe_rd_addr    in   5        W-stage destination register
//  i_pipe_rd_data    in   XLEN     W-stage result (output of result mux)
//  i_lu_valid        in   1        LU result valid
//  o_lu_ready        out  1        arbiter can accept LU result
//  i_lu_rd_addr      in   5        LU destination register
//  i_lu_rd_data      in   XLEN     LU result
//  o_rf_wr_en        out  1        regfile write enable
//  o_rf_rd_addr      out  5        regfile write address
//  o_rf_rd_data      out  XLEN     regfile write data
//  o_stall_req       out  1        request hazard unit to bubble W stage next cycle
//  o_fifo_count      out  clog2(DEPTH)+1  occupied FIFO entries
// BEHAVIOUR
//  - Reset (i_rstn=0 at posedge): FIFO empty, all kill bits 0, starve_cnt=0. While
//    i_rstn=0: o_rf_wr_en=0, o_rf_rd_addr=0, o_rf_rd_data=0, o_lu_ready=0,
//    o_stall_req=0, o_fifo_count=0. A reset mid-drain discards all buffered entries.
//  - pipe_wr = i_pipe_wr_en && i_pipe_rd_addr!=0 (x0 writes are never forwarded).
//  - Write port (combinational): pipe_wr -> W-stage rd/data; else head valid and
//    not killed -> head rd/data; else o_rf_wr_en=0, addr/data=0.
//  - o_lu_ready = i_rstn && (count<DEPTH). Push on i_lu_valid && o_lu_ready.
//    Pushed entry with rd=x0 is accepted and discarded (not stored).
//  - Pop when head valid and (head killed or !pipe_wr). Killed head pops silently
//    (no write), even in a cycle with pipe_wr. Push and pop in same cycle allowed.
//  - Minimum LU-to-regfile latency: 1 cycle (result written cycle after push).
//  - WAW kill: on pipe_wr, every stored entry with rd==i_pipe_rd_addr gets kill=1;
//    an entry pushed in the same cycle with equal rd is stored with kill=1
//    (LU result is older than the W-stage instruction).
//  - starve_cnt: 0 when FIFO empty or on a pop; else +1 per cycle, saturating at
//    STARVE_LIMIT.
//  - o_stall_req = (count==DEPTH) || (starve_cnt==STARVE_LIMIT). Hazard unit
//    responds by holding i_pipe_wr_en=0 next cycle, guaranteeing a drain.
//  - Pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
// TESTING
//  1 Reset: drive i_rstn=0 with i_lu_valid=1 -> o_lu_ready=0, o_rf_wr_en=0,
//    count=0; no entry stored after release.
//  2 Idle drain: push LU rd=5 data=0xDEAD_BEEF, pipe idle -> next cycle
//    o_rf_wr_en=1, addr=5, data=0xDEADBEEF; count returns to 0.
//  3 Priority: LU rd=7 buffered, pipe writes rd=3 for 3 cycles -> port shows rd=3
//    each cycle; rd=7 written on first idle cycle; count 1 throughout, then 0.
//  4 Full: DEPTH=4, 4 pushes while pipe writes rd=1 every cycle -> count=4,
//    o_lu_ready=0, o_stall_req=1; one idle cycle -> one pop, ready=1.
//  5 WAW kill: LU rd=9 buffered, pipe writes rd=9 data=0x11 -> regfile gets 0x11;
//    entry pops next cycle with o_rf_wr_en=0; x9 keeps 0x11.
//  6 Starvation: one entry, pipe writes rd!=entry for 8 cycles -> o_stall_req=1
//    on 8th; pipe idle -> pop, starve_cnt=0, o_stall_req=0.

Source files
------------

// File: rtl/riscv_wb_port_arbiter.sv
// Register-file write-port arbiter: W-stage writes win, long-latency unit results
// wait in a small FIFO and drain on idle port cycles, with WAW kill and starvation stall.
module riscv_wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_pipe_wr_en,
  input  logic [4:0]                 i_pipe_rd_addr,
  input  logic [XLEN-1:0]            i_pipe_rd_data,
  input  logic                       i_lu_valid,
  output logic                       o_lu_ready,
  input  logic [4:0]                 i_lu_rd_addr,
  input  logic [XLEN-1:0]            i_lu_rd_data,
  output logic                       o_rf_wr_en,
  output logic [4:0]                 o_rf_rd_addr,
  output logic [XLEN-1:0]            o_rf_rd_data,
  output logic                       o_stall_req,
  output logic [$clog2(DEPTH):0]     o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] kill_q;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [SW-1:0]   starve_cnt;
  logic [SW-1:0]   starve_next;

  logic pipe_wr;
  logic head_valid;
  logic head_kill;
  logic lu_ready;
  logic push;
  logic store;
  logic pop;

  always_comb begin
    pipe_wr    = i_pipe_wr_en && (i_pipe_rd_addr != 5'd0);
    head_valid = (count != '0);
    head_kill  = kill_q[rptr];
    pop        = i_rstn && head_valid && (head_kill || !pipe_wr);
    lu_ready   = i_rstn && (count < CW'(DEPTH));
    push       = i_lu_valid && lu_ready;
    // x0 results are acknowledged to the LU but never occupy a slot
    store      = push && (i_lu_rd_addr != 5'd0);
  end

  always_comb begin
    count_next = count;
    case ({store, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    starve_next = starve_cnt;
    if (pop || (count_next == '0)) begin
      starve_next = '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      kill_q     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_wr && (rd_q[i] == i_pipe_rd_addr)) begin
          kill_q[i] <= 1'b1;
        end
      end
      // a result pushed alongside a W-stage write to the same rd is older, so it is dead on arrival
      if (store) begin
        kill_q[wptr] <= pipe_wr && (i_lu_rd_addr == i_pipe_rd_addr);
        wptr         <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      count      <= count_next;
      starve_cnt <= starve_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (store) begin
      rd_q[wptr]   <= i_lu_rd_addr;
      data_q[wptr] <= i_lu_rd_data;
    end
  end

  always_comb begin
    o_rf_wr_en   = 1'b0;
    o_rf_rd_addr = 5'd0;
    o_rf_rd_data = '0;
    if (i_rstn) begin
      if (pipe_wr) begin
        o_rf_wr_en   = 1'b1;
        o_rf_rd_addr = i_pipe_rd_addr;
        o_rf_rd_data = i_pipe_rd_data;
      end else if (head_valid && !head_kill) begin
        o_rf_wr_en   = 1'b1;
        o_rf_rd_addr = rd_q[rptr];
        o_rf_rd_data = data_q[rptr];
      end
    end
  end

  assign o_lu_ready   = lu_ready;
  assign o_stall_req  = i_rstn && ((count == CW'(DEPTH)) || (starve_cnt == SW'(STARVE_LIMIT)));
  assign o_fifo_count = i_rstn ? count : '0;

endmodule

// File: tb/tb_riscv_wb_port_arbiter.sv
// Directed bench for riscv_wb_port_arbiter: vector table plus hand-written
// sequences for buffer-full and starvation behaviour.
module tb_riscv_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pipe_wr_en;
  logic [4:0]  pipe_rd_addr;
  logic [31:0] pipe_rd_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd_addr;
  logic [31:0] lu_rd_data;
  logic        rf_wr_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        stall_req;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  riscv_wb_port_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_pipe_wr_en(pipe_wr_en), .i_pipe_rd_addr(pipe_rd_addr), .i_pipe_rd_data(pipe_rd_data),
    .i_lu_valid(lu_valid), .o_lu_ready(lu_ready),
    .i_lu_rd_addr(lu_rd_addr), .i_lu_rd_data(lu_rd_data),
    .o_rf_wr_en(rf_wr_en), .o_rf_rd_addr(rf_rd_addr), .o_rf_rd_data(rf_rd_data),
    .o_stall_req(stall_req), .o_fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        pen;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic        stall;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl [36];

  function automatic vec_t mk(logic r, logic pe, logic [4:0] pr, logic [31:0] pd,
                              logic l, logic [4:0] lr, logic [31:0] ld,
                              logic w, logic [4:0] a, logic [31:0] d,
                              logic rd, logic st, logic [2:0] c);
    vec_t v;
    v.rstn = r; v.pen = pe; v.prd = pr; v.pdata = pd;
    v.lv = l; v.lrd = lr; v.ldata = ld;
    v.wr = w; v.addr = a; v.data = d; v.rdy = rd; v.stall = st; v.cnt = c;
    return v;
  endfunction

  task automatic check(string tag, string field, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", tag, field, got, want);
    end
  endtask

  // drive one cycle's inputs after the falling edge, sample outputs before the rising edge
  task automatic drive(logic r, logic pe, logic [4:0] pr, logic [31:0] pd,
                       logic l, logic [4:0] lr, logic [31:0] ld);
    @(negedge clk);
    rstn = r; pipe_wr_en = pe; pipe_rd_addr = pr; pipe_rd_data = pd;
    lu_valid = l; lu_rd_addr = lr; lu_rd_data = ld;
    #1;
  endtask

  task automatic expect_out(string tag, logic w, logic [4:0] a, logic [31:0] d,
                            logic rd, logic st, logic [2:0] c);
    check(tag, "wr_en", {31'd0, rf_wr_en}, {31'd0, w});
    check(tag, "addr", {27'd0, rf_rd_addr}, {27'd0, a});
    check(tag, "data", rf_rd_data, d);
    check(tag, "ready", {31'd0, lu_ready}, {31'd0, rd});
    check(tag, "stall", {31'd0, stall_req}, {31'd0, st});
    check(tag, "count", {29'd0, fifo_count}, {29'd0, c});
  endtask

  initial begin
    rstn = 1'b0; pipe_wr_en = 1'b0; pipe_rd_addr = '0; pipe_rd_data = '0;
    lu_valid = 1'b0; lu_rd_addr = '0; lu_rd_data = '0;

    //            rstn pen prd    pdata         lv lrd    ldata          wr addr   data          rdy st cnt
    tbl[0]  = mk(0, 1, 5'd2,  32'h22,       1, 5'd4,  32'h44,       0, 5'd0,  32'h0,        0, 0, 3'd0);
    tbl[1]  = mk(0, 1, 5'd2,  32'h22,       1, 5'd4,  32'h44,       0, 5'd0,  32'h0,        0, 0, 3'd0);
    tbl[2]  = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[3]  = mk(1, 0, 5'd0,  32'h0,        1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[4]  = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd5,  32'hDEADBEEF, 1, 0, 3'd1);
    tbl[5]  = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[6]  = mk(1, 1, 5'd3,  32'h33,       1, 5'd7,  32'h77,       1, 5'd3,  32'h33,       1, 0, 3'd0);
    tbl[7]  = mk(1, 1, 5'd3,  32'h34,       0, 5'd0,  32'h0,        1, 5'd3,  32'h34,       1, 0, 3'd1);
    tbl[8]  = mk(1, 1, 5'd3,  32'h35,       0, 5'd0,  32'h0,        1, 5'd3,  32'h35,       1, 0, 3'd1);
    tbl[9]  = mk(1, 1, 5'd3,  32'h36,       0, 5'd0,  32'h0,        1, 5'd3,  32'h36,       1, 0, 3'd1);
    tbl[10] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd7,  32'h77,       1, 0, 3'd1);
    tbl[11] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[12] = mk(1, 1, 5'd0,  32'h99,       1, 5'd0,  32'hAA,       0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[13] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[14] = mk(1, 0, 5'd0,  32'h0,        1, 5'd6,  32'h66,       0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[15] = mk(1, 1, 5'd0,  32'h55,       0, 5'd0,  32'h0,        1, 5'd6,  32'h66,       1, 0, 3'd1);
    tbl[16] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[17] = mk(1, 0, 5'd0,  32'h0,        1, 5'd9,  32'h99999999, 0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[18] = mk(1, 1, 5'd9,  32'h11,       0, 5'd0,  32'h0,        1, 5'd9,  32'h11,       1, 0, 3'd1);
    tbl[19] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd1);
    tbl[20] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[21] = mk(1, 1, 5'd10, 32'h1010,     1, 5'd10, 32'hBAD,      1, 5'd10, 32'h1010,     1, 0, 3'd0);
    tbl[22] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd1);
    tbl[23] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[24] = mk(1, 0, 5'd0,  32'h0,        1, 5'd12, 32'hC,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[25] = mk(1, 1, 5'd12, 32'h12,       0, 5'd0,  32'h0,        1, 5'd12, 32'h12,       1, 0, 3'd1);
    tbl[26] = mk(1, 1, 5'd13, 32'h13,       0, 5'd0,  32'h0,        1, 5'd13, 32'h13,       1, 0, 3'd1);
    tbl[27] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[28] = mk(1, 0, 5'd0,  32'h0,        1, 5'd14, 32'hE,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[29] = mk(1, 0, 5'd0,  32'h0,        1, 5'd15, 32'hF,        1, 5'd14, 32'hE,        1, 0, 3'd1);
    tbl[30] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd15, 32'hF,        1, 0, 3'd1);
    tbl[31] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd0);
    tbl[32] = mk(1, 1, 5'd1,  32'h1,        1, 5'd16, 32'h16,       1, 5'd1,  32'h1,        1, 0, 3'd0);
    tbl[33] = mk(1, 1, 5'd1,  32'h2,        1, 5'd17, 32'h17,       1, 5'd1,  32'h2,        1, 0, 3'd1);
    tbl[34] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 3'd0);
    tbl[35] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 3'd0);

    for (int i = 0; i < 36; i++) begin
      drive(tbl[i].rstn, tbl[i].pen, tbl[i].prd, tbl[i].pdata,
            tbl[i].lv, tbl[i].lrd, tbl[i].ldata);
      expect_out($sformatf("v%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].data,
                 tbl[i].rdy, tbl[i].stall, tbl[i].cnt);
    end

    // buffer full: four pushes while the W stage owns the port every cycle
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 5'd1, 32'h100 + k, 1, 5'(20 + k), 32'h100 + 32'(20 + k));
      expect_out($sformatf("full_push%0d", k), 1, 5'd1, 32'h100 + k, 1, 0, 3'(k));
    end
    drive(1, 1, 5'd1, 32'h1FF, 1, 5'd24, 32'h124);
    expect_out("full_blocked", 1, 5'd1, 32'h1FF, 0, 1, 3'd4);
    drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    expect_out("full_drain0", 1, 5'd20, 32'h114, 0, 1, 3'd4);
    drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    expect_out("full_drain1", 1, 5'd21, 32'h115, 1, 0, 3'd3);
    drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    expect_out("full_drain2", 1, 5'd22, 32'h116, 1, 0, 3'd2);
    drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    expect_out("full_drain3", 1, 5'd23, 32'h117, 1, 0, 3'd1);
    drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    expect_out("full_empty", 0, 5'd0, 32'h0, 1, 0, 3'd0);

    // starvation: one entry blocked by W-stage writes to a different rd
    drive(1, 1, 5'd2, 32'h200, 1, 5'd25, 32'h25);
    expect_out("starve_push", 1, 5'd2, 32'h200, 1, 0, 3'd0);
    for (int k = 1; k <= 8; k++) begin
      drive(1, 1, 5'd2, 32'h200 + k, 0, 5'd0, 32'h0);
      expect_out($sformatf("starve%0d", k), 1, 5'd2, 32'h200 + k, 1, (k == 8), 3'd1);
    end
    drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    expect_out("starve_drain", 1, 5'd25, 32'h25, 1, 1, 3'd1);
    drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    expect_out("starve_clear", 0, 5'd0, 32'h0, 1, 0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
